// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: three-stage pipelined Karatsuba multiplier.
// Valid/ready handshake, signed/unsigned per op, sideband tag.
module karatsuba_mult_pipe #(
  parameter int K     = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [K-1:0]     in_x,
  input  logic [K-1:0]     in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*K-1:0]   out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       inflight
);

  localparam int H = K / 2;

  if ((K % 2) != 0 || K < 4) begin : g_bad_k
    $error("karatsuba_mult_pipe: K must be even and >= 4");
  end

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [TAG_W-1:0] tag;
    logic [H-1:0]     xh;
    logic [H-1:0]     xl;
    logic [H-1:0]     yh;
    logic [H-1:0]     yl;
    logic [H:0]       r;
    logic [H:0]       s;
  } stage1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [TAG_W-1:0] tag;
    logic [K-1:0]     p;
    logic [K-1:0]     q;
    logic [K+1:0]     t;
  } stage2_t;

  stage1_t        s1;
  stage2_t        s2;
  logic           en;
  logic           in_xfer;
  logic           out_xfer;
  logic           x_neg;
  logic           y_neg;
  logic [K-1:0]   x_mag;
  logic [K-1:0]   y_mag;
  logic [K+1:0]   m;
  logic [2*K-1:0] u;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign in_xfer  = in_valid & en;
  assign out_xfer = out_valid & out_ready;

  // Operand magnitudes; -2^(K-1) maps to 2^(K-1), still K bits.
  always_comb begin
    x_neg = in_signed & in_x[K-1];
    y_neg = in_signed & in_y[K-1];
    x_mag = x_neg ? -in_x : in_x;
    y_mag = y_neg ? -in_y : in_y;
  end

  // S1: split magnitudes into halves and form the half sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      s1.sign  <= in_signed & (in_x[K-1] ^ in_y[K-1]);
      s1.tag   <= in_tag;
      s1.xh    <= x_mag[K-1:H];
      s1.xl    <= x_mag[H-1:0];
      s1.yh    <= y_mag[K-1:H];
      s1.yl    <= y_mag[H-1:0];
      s1.r     <= {1'b0, x_mag[K-1:H]} + {1'b0, x_mag[H-1:0]};
      s1.s     <= {1'b0, y_mag[K-1:H]} + {1'b0, y_mag[H-1:0]};
    end
  end

  // S2: the three half-width products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (en) begin
      s2.valid <= s1.valid;
      s2.sign  <= s1.sign;
      s2.tag   <= s1.tag;
      s2.p     <= {{H{1'b0}}, s1.xh} * {{H{1'b0}}, s1.yh};
      s2.q     <= {{H{1'b0}}, s1.xl} * {{H{1'b0}}, s1.yl};
      s2.t     <= {{(H+1){1'b0}}, s1.r} * {{(H+1){1'b0}}, s1.s};
    end
  end

  // Recombine; the bit above 2K is always zero so it is not formed.
  always_comb begin
    m = s2.t - {2'b00, s2.p} - {2'b00, s2.q};
    u = {s2.p, {K{1'b0}}}
      + ({{(K-2){1'b0}}, m} << H)
      + {{K{1'b0}}, s2.q};
  end

  // S3: apply the result sign and present the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2.valid;
      out_z     <= s2.sign ? -u : u;
      out_tag   <= s2.tag;
    end
  end

  // Occupancy: accepted minus delivered operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 2'd0;
    end else begin
      unique case (1'b1)
        in_xfer & ~out_xfer: inflight <= inflight + 2'd1;
        out_xfer & ~in_xfer: inflight <= inflight - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// tb_karatsuba_mult_pipe: scoreboard bench, K=64 main DUT plus
// width-sweep DUTs at K=4 (exhaustive), 8 and 48 (random).
module tb_karatsuba_mult_pipe;

  localparam int K = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rst_sw_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [63:0]  in_x;
  logic [63:0]  in_y;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_z;
  logic [3:0]   out_tag;
  logic [1:0]   inflight;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  karatsuba_mult_pipe #(.K(K), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_x(in_x), .in_y(in_y),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_tag(out_tag),
    .inflight(inflight)
  );

  typedef struct {
    logic [127:0] z;
    logic [3:0]   tag;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sq[$];
  exp_t         me;
  int           exp_if = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_z;
  logic [3:0]   prev_tag;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: sign-extend to 128 bits, multiply, keep 2k bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x,
      input logic [63:0] y, input bit sg, input int k);
    logic [127:0] hi = ~128'd0 << k;
    logic [127:0] xe = {64'd0, x};
    logic [127:0] ye = {64'd0, y};
    if (sg && x[k-1]) xe = xe | hi;
    if (sg && y[k-1]) ye = ye | hi;
    return (xe * ye) & ~(~128'd0 << (2 * k));
  endfunction

  function automatic logic [63:0] rop(input int k);
    logic [63:0] msk = ~64'd0 >> (64 - k);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return msk;
      2: return 64'd1 << (k - 1);
      3: return 64'd1;
      default: return {$urandom, $urandom} & msk;
    endcase
  endfunction

  function automatic logic rnd_rdy();
    return $urandom_range(0, 3) != 0;
  endfunction

  // Main monitor: handshake rules, occupancy, stall stability, results.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_if     = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
      chk("inflight", 128'(inflight), 128'(exp_if));
      if (prev_stall) begin
        chk("stall_valid", 128'(out_valid), 128'd1);
        chk("stall_z", out_z, prev_z);
        chk("stall_tag", 128'(out_tag), 128'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected: got z=%h tag=%0d want none",
                   out_z, out_tag);
        end else begin
          me = sq.pop_front();
          chk("z", out_z, me.z);
          chk("tag", 128'(out_tag), 128'(me.tag));
          if (me.lat) chk("latency", 128'(cyc), 128'(me.acc + 3));
        end
      end
      exp_if = exp_if + ((in_valid && in_ready) ? 1 : 0)
                      - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_z     = out_z;
      prev_tag   = out_tag;
    end
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y,
      input bit sg, input logic [3:0] tag, input logic [127:0] exp,
      input bit rnd, input bit lat);
    int tries = 0;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_signed = sg;
    in_tag    = tag;
    out_ready = rnd ? rnd_rdy() : 1'b1;
    #1;
    while (!in_ready) begin
      tries++;
      if (tries > 200) begin
        $display("FAIL send_timeout: got in_ready=0 want 1");
        $fatal(1, "stuck");
      end
      @(posedge clk);
      #1;
      out_ready = rnd ? rnd_rdy() : 1'b1;
      #1;
    end
    e.z   = exp;
    e.tag = tag;
    e.acc = cyc;
    e.lat = lat;
    sq.push_back(e);
  endtask

  task automatic idle(input bit rnd);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_x      = {$urandom, $urandom};
    out_ready = rnd ? rnd_rdy() : 1'b1;
  endtask

  task automatic drain();
    idle(0);
    for (int i = 0; i < 20 && sq.size() != 0; i++) @(posedge clk);
    total++;
    if (sq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sq.size());
      sq.delete();
    end
  endtask

  // Width sweep DUTs with their own driver and monitor.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int KW = (g == 0) ? 4 : ((g == 1) ? 8 : 48);
    typedef struct {
      logic [127:0] z;
      logic [3:0]   tag;
    } se_t;
    logic            iv, ir, isg, ov, ordy;
    logic [KW-1:0]   ix, iy;
    logic [3:0]      itag, otag;
    logic [2*KW-1:0] oz;
    logic [1:0]      infl;
    se_t             q[$];
    se_t             mq;
    int              cnt = 0;
    bit              done = 0;

    karatsuba_mult_pipe #(.K(KW), .TAG_W(4)) u_sw (
      .clk(clk), .rst_n(rst_sw_n),
      .in_valid(iv), .in_ready(ir),
      .in_signed(isg), .in_x(ix), .in_y(iy), .in_tag(itag),
      .out_valid(ov), .out_ready(ordy),
      .out_z(oz), .out_tag(otag), .inflight(infl)
    );

    initial begin
      logic [63:0] rx, ry;
      bit          s;
      int          n, tries;
      se_t         e;
      iv = 0; ordy = 0; isg = 0; ix = '0; iy = '0; itag = '0;
      n = (KW == 4) ? 512 : 10000;
      wait (rst_sw_n === 1'b1);
      for (int i = 0; i < n; i++) begin
        if (KW == 4) begin
          s  = i[8];
          rx = 64'(i[7:4]);
          ry = 64'(i[3:0]);
        end else begin
          s  = 1'($urandom_range(0, 1));
          rx = rop(KW);
          ry = rop(KW);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
            iv   = 0;
            ordy = rnd_rdy();
          end
        end
        @(posedge clk);
        #1;
        iv = 1; isg = s; ix = rx[KW-1:0]; iy = ry[KW-1:0];
        itag = i[3:0];
        ordy = rnd_rdy();
        #1;
        tries = 0;
        while (!ir) begin
          tries++;
          if (tries > 200) begin
            $display("FAIL k%0d_timeout: got in_ready=0 want 1", KW);
            $fatal(1, "stuck");
          end
          @(posedge clk);
          #1;
          ordy = rnd_rdy();
          #1;
        end
        e.z   = ref_mul(rx, ry, s, KW);
        e.tag = i[3:0];
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      iv   = 0;
      ordy = 1;
      for (int j = 0; j < 20 && q.size() != 0; j++) @(posedge clk);
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL k%0d_drain: got %0d pending want 0", KW, q.size());
      end
      done = 1;
    end

    always @(negedge clk) begin
      if (rst_sw_n) begin
        chk($sformatf("k%0d_inflight", KW), 128'(infl), 128'(cnt));
        if (ov && ordy) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL k%0d_unexpected: got z=%h want none", KW, oz);
          end else begin
            mq = q.pop_front();
            chk($sformatf("k%0d_z", KW), 128'(oz), mq.z);
            chk($sformatf("k%0d_tag", KW), 128'(otag), 128'(mq.tag));
          end
        end
        cnt = cnt + ((iv && ir) ? 1 : 0) - ((ov && ordy) ? 1 : 0);
      end
    end
  end

  initial begin
    logic [63:0] x, y;
    bit          sg;
    rst_n = 0; rst_sw_n = 0;
    in_valid = 0; in_signed = 0; in_x = '0; in_y = '0; in_tag = '0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_inflight", 128'(inflight), 128'd0);
    chk("rst_z", out_z, 128'd0);
    chk("rst_tag", 128'(out_tag), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1;
    rst_sw_n = 1;

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd1,
         128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, 1);
    send(64'd0, 64'h1234, 0, 4'd2, 128'd0, 0, 1);
    send(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'd3,
         128'h0000_0000_0000_0000_8000_0000_0000_0000, 0, 1);
    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 4'd4,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 0, 1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 4'd5,
         128'h4000_0000_0000_0000_0000_0000_0000_0000, 0, 1);
    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, 4'd6,
         128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1, 0, 1);
    send(64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'd7,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, 0, 1);
    drain();

    for (int i = 0; i < 8; i++) begin
      x  = {$urandom, $urandom};
      y  = {$urandom, $urandom};
      sg = 1'(i % 2);
      send(x, y, sg, 4'(i), ref_mul(x, y, sg, 64), 0, 1);
      if (i >= 3) chk("stream_inflight", 128'(inflight), 128'd3);
    end
    drain();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      sg = 1'($urandom_range(0, 1));
      x  = rop(64);
      y  = rop(64);
      send(x, y, sg, 4'(i), ref_mul(x, y, sg, 64), 1, 0);
    end
    drain();

    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom};
      send(x, x, 0, 4'(i), ref_mul(x, x, 0, 64), 0, 1);
    end
    @(posedge clk);
    #1;
    chk("pre_rst_inflight", 128'(inflight), 128'd3);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_inflight", 128'(inflight), 128'd0);
    sq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    send(64'd11, 64'hFFFF_FFFF_FFFF_FFFE, 1, 4'd9,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEA, 0, 1);
    drain();

    for (int i = 0; i < 60000 &&
         !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++)
      @(posedge clk);
    total++;
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) begin
      bad++;
      $display("FAIL sweep_timeout: got unfinished want finished");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
